am_modulator: RTL and testbench

- Transmit-direction counterpart of am_detector: generates a full-carrier AM test signal from signed baseband audio.
- A phase-accumulator NCO sets the carrier frequency. A quarter-wave sine LUT produces the carrier, which is scaled by an offset envelope.
- Runs in the aclk (16 MHz sample) domain. Produces 14-bit signed RF samples in ADC format, used for loopback testing of am_detector and for driving an RF DAC.

---
 rtl/am_pkg.sv | 35 +++
 rtl/am_modulator_sine_lut_q.sv | 52 +++++
 rtl/am_modulator.sv | 125 ++++++++++++
 tb/tb_am_modulator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared constants, sample types and the sine table generator for the AM modulator.
package am_pkg;

    localparam int PHASE_W   = 27;
    localparam int IN_W      = 16;
    localparam int OUT_W     = 14;
    localparam int LUT_AW    = 8;
    localparam int LUT_DEPTH = 257;
    localparam int SINE_W    = 16;
    localparam int OUT_SHIFT = 17;
    localparam int PH_TOP_W  = LUT_AW + 2;

    typedef logic signed [OUT_W-1:0]  rf_t;
    typedef logic signed [IN_W-1:0]   bb_t;
    typedef logic signed [SINE_W-1:0] sine_t;

    // round(32767 * sin(pi*j/512)) evaluated with Q30 fixed-point Taylor terms,
    // so the table folds to constants at elaboration without real arithmetic.
    function automatic logic [SINE_W-2:0] sine_rom_entry(input int j);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (64'sd3373259426 * longint'(j)) / 64'sd512;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        return (SINE_W-1)'((sum * 64'sd32767 + 64'sd536870912) >>> 30);
    endfunction

endpackage

// File: rtl/am_modulator_sine_lut_q.sv
// Quarter-wave sine lookup: 10-bit phase in, signed 16-bit sine out, two registered stages.
module sine_lut_q
    import am_pkg::*;
(
    input  logic                aclk,
    input  logic                rst_n,
    input  logic [PH_TOP_W-1:0] i_phase,
    output sine_t               o_sine
);

    logic [1:0]        w_q;
    logic [LUT_AW-1:0] w_k;
    logic [LUT_AW:0]   w_idx;
    logic [SINE_W-2:0] w_rom [0:LUT_DEPTH-1];

    logic [SINE_W-2:0] r_mag;
    logic              r_neg;
    sine_t             r_sine;

    assign w_q = i_phase[PH_TOP_W-1 -: 2];
    assign w_k = i_phase[LUT_AW-1:0];

    // Odd quadrants run the table backwards; index 256 is the peak entry.
    assign w_idx = w_q[0] ? ((LUT_AW+1)'(256) - {1'b0, w_k}) : {1'b0, w_k};

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
        assign w_rom[g] = sine_rom_entry(g);
    end

    // Stage 1: ROM read and remember whether this is the negative half-wave.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag <= '0;
            r_neg <= 1'b0;
        end else begin
            r_mag <= w_rom[w_idx];
            r_neg <= w_q[1];
        end
    end

    // Stage 2: apply the sign of the half-wave.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sine <= '0;
        end else begin
            r_sine <= r_neg ? -$signed({1'b0, r_mag}) : $signed({1'b0, r_mag});
        end
    end

    assign o_sine = r_sine;

endmodule

// File: rtl/am_modulator.sv
// Full-carrier AM generator: NCO carrier scaled by an offset baseband envelope.
module am_modulator
    import am_pkg::*;
(
    input  logic               aclk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_valid,
    input  logic [1:0]         mod_depth,
    input  bb_t                baseband,
    input  logic               i_valid,
    output rf_t                rf,
    output logic               o_valid
);

    logic [PHASE_W-1:0]  r_inc;
    logic [PHASE_W-1:0]  r_acc;

    logic [PH_TOP_W-1:0] r_phase;
    bb_t                 r_env1;
    bb_t                 r_env2;
    bb_t                 r_env3;
    logic                r_v1;
    logic                r_v2;
    logic                r_v3;
    logic                r_v4;
    logic signed [31:0]  r_prod;
    rf_t                 r_rf;
    logic                r_valid;

    logic [2:0]          w_shamt;
    bb_t                 w_bb_sh;
    bb_t                 w_env;
    sine_t               w_sine;
    logic                w_unused;

    // Offset envelope; the +2^14 lift keeps it non-negative for every depth.
    assign w_shamt = {1'b0, mod_depth} + 3'd1;
    assign w_bb_sh = baseband >>> w_shamt;
    assign w_env   = w_bb_sh + 16'sd16384;

    // Increment register; a load in a sample cycle only affects later samples.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc <= '0;
        end else if (phase_valid) begin
            r_inc <= phase_inc;
        end
    end

    // Phase accumulator advances once per accepted sample, wrapping naturally.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_valid) begin
            r_acc <= r_acc + r_inc;
        end
    end

    // S1: capture the current phase and envelope for this sample.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_env1  <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_phase <= r_acc[PHASE_W-1 -: PH_TOP_W];
            r_env1  <= w_env;
            r_v1    <= i_valid;
        end
    end

    sine_lut_q u_sine (
        .aclk    (aclk),
        .rst_n   (rst_n),
        .i_phase (r_phase),
        .o_sine  (w_sine)
    );

    // S2/S3: envelope and valid ride alongside the two LUT stages.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_env2 <= '0;
            r_env3 <= '0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
        end else begin
            r_env2 <= r_env1;
            r_env3 <= r_env2;
            r_v2   <= r_v1;
            r_v3   <= r_v2;
        end
    end

    // S4: envelope times carrier.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_v4   <= 1'b0;
        end else begin
            r_prod <= 32'(r_env3) * 32'(w_sine);
            r_v4   <= r_v3;
        end
    end

    // S5: output register; rf holds between samples.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf    <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_v4) begin
                r_rf <= r_prod[OUT_SHIFT+OUT_W-1 -: OUT_W];
            end
            r_valid <= r_v4;
        end
    end

    // |prod| < 2^30, so the sign bit and the discarded fraction carry no information.
    assign w_unused = ^{r_prod[31], r_prod[OUT_SHIFT-1:0]};

    assign rf      = r_rf;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_am_modulator.sv
// Self-checking bench for am_modulator against a real-arithmetic AM reference.
module tb_am_modulator;
    import am_pkg::*;

    logic               aclk        = 1'b0;
    logic               rst_n       = 1'b0;
    logic [PHASE_W-1:0] phase_inc   = '0;
    logic               phase_valid = 1'b0;
    logic [1:0]         mod_depth   = '0;
    bb_t                baseband    = '0;
    logic               i_valid     = 1'b0;
    rf_t                rf;
    logic               o_valid;

    am_modulator dut (
        .aclk        (aclk),
        .rst_n       (rst_n),
        .phase_inc   (phase_inc),
        .phase_valid (phase_valid),
        .mod_depth   (mod_depth),
        .baseband    (baseband),
        .i_valid     (i_valid),
        .rf          (rf),
        .o_valid     (o_valid)
    );

    always #5 aclk = ~aclk;

    localparam longint ACC_MASK = (64'sd1 <<< PHASE_W) - 1;

    typedef struct {
        longint val;
        longint due;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint m_acc = 0;
    longint m_inc = 0;
    longint exp_rf = 0;
    exp_t   q[$];
    longint got[$];

    // AM sample from first principles: carrier = round(32767*sin(2*pi*phase)).
    function automatic longint ref_sample(input longint acc, input int bb, input int md);
        real    pi_r;
        real    s;
        int     p;
        int     mag;
        int     sine;
        int     env;
        longint prod;
        pi_r = 3.14159265358979323846;
        p    = int'(acc >> 17);
        s    = $sin(2.0 * pi_r * real'(p) / 1024.0);
        mag  = $rtoi(((s < 0.0) ? -s : s) * 32767.0 + 0.5);
        sine = (s < 0.0) ? -mag : mag;
        env  = (bb >>> (1 + md)) + 16384;
        prod = longint'(env) * longint'(sine);
        return prod >>> 17;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge aclk);
        cyc++;
        if (rst_n) begin
            if (i_valid) begin
                e.val = ref_sample(m_acc, int'(baseband), int'(mod_depth));
                e.due = cyc + 4;
                q.push_back(e);
                m_acc = (m_acc + m_inc) & ACC_MASK;
            end
            if (phase_valid) m_inc = longint'(phase_inc);
        end
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("o_valid_pulse", longint'(o_valid), 1);
            exp_rf = q[0].val;
            got.push_back(longint'(rf));
            void'(q.pop_front());
        end else begin
            chk("o_valid_idle", longint'(o_valid), 0);
        end
        chk("rf", longint'(rf), exp_rf);
    endtask

    task automatic drain();
        i_valid     = 1'b0;
        phase_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drain_empty", longint'(q.size()), 0);
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rf", longint'(rf), 0);
        chk("rst_async_valid", longint'(o_valid), 0);
        q.delete();
        m_acc  = 0;
        m_inc  = 0;
        exp_rf = 0;
    endtask

    task automatic check_pattern(input string tag, input int n, input longint pat [4]);
        chk({tag, "_count"}, longint'(got.size()), longint'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk(tag, got[i], pat[i % 4]);
    endtask

    longint pat_q [4];
    longint pat_w [4];
    longint pat_z [4];
    longint pat5  [6];

    initial begin
        pat_q = '{0, 8191, 0, -8192};
        pat_w = '{0, -8192, 0, 8191};
        pat_z = '{0, 0, 0, 0};
        pat5  = '{0, 8191, 0, -8192, -8192, -8192};

        repeat (3) step();
        #2 rst_n = 1'b1;

        // warm-up stream so the reset below lands on a busy pipeline
        for (int i = 0; i < 20; i++) begin
            i_valid     = 1'b1;
            phase_valid = (i == 0);
            phase_inc   = PHASE_W'($urandom);
            baseband    = 16'($urandom);
            mod_depth   = 2'($urandom_range(0, 3));
            step();
        end

        async_reset();
        repeat (3) step();
        i_valid = 1'b0;
        #2 rst_n = 1'b1;

        // quarter-rate carrier at full positive baseband
        phase_inc   = PHASE_W'(1 << 25);
        phase_valid = 1'b1;
        step();
        phase_valid = 1'b0;
        baseband    = 16'sd32767;
        mod_depth   = 2'd0;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            step();
        end
        drain();
        check_pattern("quarter", 8, pat_q);

        // gapped 1-of-3 input
        got.delete();
        for (int i = 0; i < 12; i++) begin
            i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            step();
            step();
        end
        drain();
        check_pattern("gapped", 12, pat_q);

        // 3/4-rate increment aliases to a reversed quarter-rate pattern
        phase_inc   = PHASE_W'(3 << 25);
        phase_valid = 1'b1;
        step();
        phase_valid = 1'b0;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            step();
        end
        drain();
        check_pattern("wrap", 8, pat_w);

        // increment change coincident with a sample
        phase_inc   = PHASE_W'(1 << 25);
        phase_valid = 1'b1;
        step();
        got.delete();
        for (int i = 0; i < 6; i++) begin
            i_valid     = 1'b1;
            phase_valid = (i == 2);
            if (i == 2) phase_inc = '0;
            step();
        end
        drain();
        chk("inc_change_count", longint'(got.size()), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("inc_change", got[i], pat5[i]);

        // full trough: zero envelope whatever the phase
        baseband  = -16'sd32768;
        mod_depth = 2'd0;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            i_valid     = 1'b1;
            phase_valid = 1'b1;
            phase_inc   = PHASE_W'($urandom);
            step();
        end
        drain();
        check_pattern("trough", 10, pat_z);

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_reset();
                step();
                step();
                #2 rst_n = 1'b1;
            end
            i_valid     = ($urandom_range(0, 9) < 7);
            phase_valid = ($urandom_range(0, 9) == 0);
            phase_inc   = PHASE_W'($urandom);
            baseband    = 16'($urandom);
            mod_depth   = 2'($urandom_range(0, 3));
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
